ss_capture: RTL

Display-side capture block for the multiplexed four-digit seven-segment bus. It samples the active-low digit-enable and segment lines driven by the display driver and recovers the four BCD digits, rejecting transients and PWM blanking. It also flags illegal segment patterns and measures display duty cycle. It sits in the test/loopback path alongside the wall-clock display, letting the design read back what is actually being shown.

---
 rtl/ss_pkg.sv | 21 ++
 rtl/ss_capture_if.sv | 18 +
 rtl/ss_segment_decoder.sv | 19 +
 rtl/ss_capture.sv | 98 +++++++++
 4 files changed

// File: rtl/ss_pkg.sv
// ss_pkg: shared constants and types for the seven-segment capture slice
package ss_pkg;
    localparam int STABLE_CYCLES_DEF = 16;
    typedef logic [1:0] digit_idx_t;
    typedef enum logic [1:0] {SMP_IDLE, SMP_BLANK, SMP_LIT} sample_t;
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    // raw active-low pin value with every segment dark
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    function automatic digit_idx_t onehot_idx(logic [3:0] en);
        return en[3] ? 2'd3 : en[2] ? 2'd2 : en[1] ? 2'd1 : 2'd0;
    endfunction
endpackage

// File: rtl/ss_capture_if.sv
// ss_capture_if: multiplexed seven-segment bus plus recovered-digit outputs
interface ss_capture_if #(parameter int WINDOW_LOG2 = 20);
    logic [3:0]           SegmentDrivers;
    logic [7:0]           SevenSegment;
    logic [3:0]           BCD3, BCD2, BCD1, BCD0;
    logic [3:0]           DigitValid;
    logic                 FrameValid;
    logic                 PatternError;
    logic [WINDOW_LOG2:0] DutyCount;
    modport master (
        output SegmentDrivers, SevenSegment,
        input  BCD3, BCD2, BCD1, BCD0, DigitValid, FrameValid, PatternError, DutyCount
    );
    modport slave (
        input  SegmentDrivers, SevenSegment,
        output BCD3, BCD2, BCD1, BCD0, DigitValid, FrameValid, PatternError, DutyCount
    );
endinterface

// File: rtl/ss_segment_decoder.sv
// ss_segment_decoder: active-high gfedcba pattern to {legal, bcd}
module ss_segment_decoder
    import ss_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       legal,
    output logic [3:0] bcd
);
    assign {legal, bcd} = pattern == SEG_0 ? 5'h10 :
                          pattern == SEG_1 ? 5'h11 :
                          pattern == SEG_2 ? 5'h12 :
                          pattern == SEG_3 ? 5'h13 :
                          pattern == SEG_4 ? 5'h14 :
                          pattern == SEG_5 ? 5'h15 :
                          pattern == SEG_6 ? 5'h16 :
                          pattern == SEG_7 ? 5'h17 :
                          pattern == SEG_8 ? 5'h18 :
                          pattern == SEG_9 ? 5'h19 : 5'h00;
endmodule

// File: rtl/ss_capture.sv
// ss_capture: recovers stable BCD digits and duty cycle from the display bus
module ss_capture
    import ss_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int WINDOW_LOG2   = 20
) (
    input  logic         Clk,
    input  logic         Reset,
    ss_capture_if.slave  bus
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int DW = WINDOW_LOG2 + 1;

    logic [3:0]             drv_q;
    logic [6:0]             seg_q;
    logic [3:0]             en;
    logic                   onehot;
    sample_t                smp;
    digit_idx_t             idx, last_idx;
    logic [6:0]             last_pat;
    logic                   same, accept, legal, frame;
    logic [CW-1:0]          cnt, cnt_n;
    logic [3:0]             dec_bcd, hit, mask, mask_n, dv;
    logic [3:0][3:0]        bcd_r;
    logic                   fv, pe;
    logic [WINDOW_LOG2-1:0] win;
    logic [DW-1:0]          lit_cnt, duty;

    assign en     = ~drv_q;
    assign onehot = en != 4'd0 && (en & (en - 4'd1)) == 4'd0;
    assign smp    = !onehot ? SMP_IDLE : seg_q == SEG_BLANK ? SMP_BLANK : SMP_LIT;
    assign idx    = onehot_idx(en);
    assign same   = idx == last_idx && seg_q == last_pat;

    // blank samples hold the count so PWM dimming cannot break a run
    always_comb begin
        cnt_n  = smp == SMP_IDLE ? '0 :
                 smp == SMP_BLANK ? cnt :
                 !same ? CW'(1) :
                 cnt == CW'(STABLE_CYCLES) ? cnt : cnt + 1'b1;
        accept = smp == SMP_LIT && same && cnt == CW'(STABLE_CYCLES - 1);
        hit    = accept && legal ? 4'b1 << idx : 4'b0;
        mask_n = mask | hit;
        frame  = mask_n == 4'hF;
    end

    ss_segment_decoder u_dec (.pattern(~seg_q), .legal(legal), .bcd(dec_bcd));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            drv_q    <= '1;
            seg_q    <= '1;
            cnt      <= '0;
            last_idx <= '0;
            last_pat <= '0;
            mask     <= '0;
            dv       <= '0;
            bcd_r    <= '0;
            fv       <= 1'b0;
            pe       <= 1'b0;
            win      <= '0;
            lit_cnt  <= '0;
            duty     <= '0;
        end else begin
            drv_q <= bus.SegmentDrivers;
            seg_q <= bus.SevenSegment[6:0];
            cnt   <= cnt_n;
            if (smp == SMP_LIT && !same) begin
                last_idx <= idx;
                last_pat <= seg_q;
            end
            mask <= frame ? 4'h0 : mask_n;
            fv   <= frame;
            pe   <= accept && !legal;
            if (accept) begin
                dv[idx] <= legal;
                if (legal) bcd_r[idx] <= dec_bcd;
            end
            win <= win + 1'b1;
            if (&win) begin
                duty    <= lit_cnt + DW'(smp == SMP_LIT);
                lit_cnt <= '0;
            end else begin
                lit_cnt <= lit_cnt + DW'(smp == SMP_LIT);
            end
        end
    end

    assign bus.BCD0         = bcd_r[0];
    assign bus.BCD1         = bcd_r[1];
    assign bus.BCD2         = bcd_r[2];
    assign bus.BCD3         = bcd_r[3];
    assign bus.DigitValid   = dv;
    assign bus.FrameValid   = fv;
    assign bus.PatternError = pe;
    assign bus.DutyCount    = duty;
endmodule
